// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx byte transmitter among NREQ
// producers, with an optional inter-byte gap and a watchdog on tx_done_tick.
module uart_tx_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              tx_start,
    output logic [7:0]        tx_din,
    input  logic              tx_done_tick,
    output logic              timeout_err
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned PW      = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   ptr, ptr_next, cur, cur_next, win;
    logic [CW-1:0]   cnt, cnt_next;
    logic [NREQ-1:0] cand, ack_next, grant_next;
    logic [7:0]      din_next, win_byte;
    logic            found, expired, start_next, err_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            cur         <= '0;
            cnt         <= '0;
            ack         <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            tx_start    <= 1'b0;
            tx_din      <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            cur         <= cur_next;
            cnt         <= cnt_next;
            ack         <= ack_next;
            grant       <= grant_next;
            busy        <= (state_next != IDLE);
            tx_start    <= start_next;
            tx_din      <= din_next;
            timeout_err <= err_next;
        end
    end

    // The requester acked this cycle still holds req; mask it so it is not re-served.
    always_comb begin
        cand     = req & ~ack;
        found    = 1'b0;
        win      = '0;
        win_byte = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && cand[i] && (PW'(i) >= ptr)) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && cand[i] && (PW'(i) < ptr)) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) win_byte = data[8*i +: 8];
        end
    end

    always_comb begin
        expired    = (cnt == CW'(TIMEOUT_CYCLES - 1));
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (tx_done_tick || expired) state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (cnt == CW'(GAP_CYCLES - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tx_start is registered off LAUNCH, so it appears the cycle after grant.
    always_comb begin
        ack_next   = '0;
        err_next   = 1'b0;
        grant_next = grant;
        din_next   = tx_din;
        start_next = (state == LAUNCH);
        cnt_next   = cnt;
        ptr_next   = ptr;
        cur_next   = cur;
        case (state)
            IDLE: begin
                if (found) begin
                    for (int unsigned i = 0; i < NREQ; i++) grant_next[i] = (win == PW'(i));
                    din_next = win_byte;
                    cur_next = win;
                end
            end
            LAUNCH: cnt_next = '0;
            WAIT: begin
                cnt_next = cnt + 1'b1;
                if (tx_done_tick) ack_next = grant;
                else if (expired) err_next = 1'b1;
                if (tx_done_tick || expired) begin
                    ptr_next = (cur == PW'(NREQ - 1)) ? '0 : cur + 1'b1;
                    cnt_next = '0;
                end
            end
            GAP:     cnt_next = cnt + 1'b1;
            default: ;
        endcase
        if (state_next == IDLE) grant_next = '0;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a transaction-level model predicts the
// launch/ack/timeout event stream; a monitor compares every event the DUT emits.
module tb_uart_tx_arbiter;

    localparam int NREQ      = 4;
    localparam int GAP       = 5;
    localparam int TMO       = 64;
    localparam int EV_LAUNCH = 0;
    localparam int EV_ACK    = 1;
    localparam int EV_TMO    = 2;

    typedef struct {
        int         kind;
        int         idx;
        int         delay;
        bit         anchored;
        logic [7:0] byte_v;
    } evt_t;

    logic              clk          = 1'b0;
    logic              reset        = 1'b1;
    logic [NREQ-1:0]   req          = '0;
    logic [8*NREQ-1:0] data         = '0;
    logic              tx_done_tick = 1'b0;
    logic [NREQ-1:0]   ack, grant;
    logic              busy, tx_start, timeout_err;
    logic [7:0]        tx_din;

    uart_tx_arbiter #(
        .NREQ(NREQ),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .data(data),
        .ack(ack),
        .grant(grant),
        .busy(busy),
        .tx_start(tx_start),
        .tx_din(tx_din),
        .tx_done_tick(tx_done_tick),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    evt_t            exp_q[$];
    int              tests = 0;
    int              fails = 0;
    int              phase_cyc = 0;
    int              last_evt_cyc = 0;
    int              mptr = 0;
    logic [NREQ-1:0] hold = '0;
    logic [NREQ-1:0] ack_last = '0;
    int              stub_n = 1;
    int              stub_cnt = 0;
    int              dead_idx = -1;
    bit              dead_armed = 1'b0;
    bit              stale = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, expv, expv, cyc);
        end
    endtask

    function automatic int bitof(input logic [NREQ-1:0] v, input int i);
        return (int'(v) >> i) & 1;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] p, input int from);
        for (int off = 0; off < NREQ; off++) begin
            int i;
            i = (from + off) % NREQ;
            if (bitof(p, i) == 1) return i;
        end
        return -1;
    endfunction

    task automatic consume(input int kind, input int vec, input int byte_v);
        evt_t e;
        int   base;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d vector 0x%0h, expected no event at cycle %0d",
                     kind, vec, cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        chk(kind == EV_ACK ? "ack_vector" : "grant_vector", vec, 1 << e.idx);
        if (kind == EV_LAUNCH) chk("tx_din", byte_v, int'(e.byte_v));
        base = e.anchored ? phase_cyc : last_evt_cyc;
        chk("event_delay", cyc - base, e.delay);
        last_evt_cyc = cyc;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            ack_last = ack;
            if (reset) begin
                if (ack != '0 || timeout_err) begin
                    chk("ack_err_exclusive", int'(ack != '0 && timeout_err), 0);
                    chk("ack_onehot0", int'($onehot0(ack)), 1);
                end
                if (tx_start) consume(EV_LAUNCH, int'(grant), int'(tx_din));
                if (ack != '0) consume(EV_ACK, int'(ack), 0);
                if (timeout_err) consume(EV_TMO, int'(grant), 0);
            end
        end
    endtask

    // Transmitter stand-in: tx_done_tick stub_n cycles after tx_start, silent once for dead_idx.
    task automatic stub();
        forever begin
            @(posedge clk);
            #1;
            tx_done_tick = 1'b0;
            if (stale) begin
                tx_done_tick = 1'b1;
                stale = 1'b0;
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) tx_done_tick = 1'b1;
            end
            @(negedge clk);
            if (tx_start) begin
                if (dead_armed && dead_idx >= 0 && int'(grant) == (1 << dead_idx)) begin
                    dead_armed = 1'b0;
                    stub_cnt   = 0;
                end else begin
                    stub_cnt = stub_n;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req = req & ~(ack_last & ~hold);
    endtask

    task automatic push(input int kind, input int idx, input int delay, input bit anch, input logic [7:0] b);
        evt_t e;
        e.kind     = kind;
        e.idx      = idx;
        e.delay    = delay;
        e.anchored = anch;
        e.byte_v   = b;
        exp_q.push_back(e);
    endtask

    // Reference: requests all rise together from idle; serve the first pending index at or
    // after the pointer. A launch follows the previous byte's ack/timeout by 2+GAP cycles.
    task automatic run_phase(input logic [NREQ-1:0] pend, input logic [NREQ-1:0] hold_m,
                             input int n, input int dead_i, input int max_serv,
                             input logic [8*NREQ-1:0] dv);
        logic [NREQ-1:0] p;
        bit armed;
        bit first;
        int served;
        int k;
        p      = pend;
        armed  = (dead_i >= 0);
        first  = 1'b1;
        served = 0;
        while (p != '0 && served < max_serv) begin
            k = pick(p, mptr);
            push(EV_LAUNCH, k, first ? 2 : 2 + GAP, first, 8'(dv >> (8 * k)));
            if (armed && k == dead_i) begin
                armed = 1'b0;
                push(EV_TMO, k, TMO, 1'b0, 8'h00);
            end else begin
                push(EV_ACK, k, n + 1, 1'b0, 8'h00);
                if (bitof(hold_m, k) == 0) p = p & ~(NREQ'(1) << k);
            end
            mptr   = (k + 1) % NREQ;
            served++;
            first  = 1'b0;
        end
        data       = dv;
        stub_n     = n;
        dead_idx   = dead_i;
        dead_armed = (dead_i >= 0);
        hold       = hold_m;
        phase_cyc  = cyc;
        req        = pend;
    endtask

    task automatic wait_quiet(input int budget);
        int k;
        k = 0;
        while (k < budget) begin
            tick();
            if (exp_q.size() == 0) begin
                req  = '0;
                hold = '0;
                if (!busy) break;
            end
            k++;
        end
        if (k >= budget) begin
            tests++;
            fails++;
            $display("FAIL phase_budget: got %0d events still pending, expected 0 within %0d cycles",
                     exp_q.size(), budget);
            exp_q.delete();
            req  = '0;
            hold = '0;
        end
        repeat (4) tick();
    endtask

    initial begin
        logic [8*NREQ-1:0] dv;
        logic [NREQ-1:0]   pend;
        int                n;
        int                d;

        fork
            monitor();
            stub();
            begin
                #900000;
                $display("FAIL global_watchdog: still running at time %0t, expected finish earlier", $time);
                $fatal(1, "global watchdog expired");
            end
        join_none

        reset = 1'b0;
        #1;
        chk("reset_ack", int'(ack), 0);
        chk("reset_grant", int'(grant), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_tx_start", int'(tx_start), 0);
        chk("reset_tx_din", int'(tx_din), 0);
        chk("reset_timeout_err", int'(timeout_err), 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();

        run_phase(4'b1111, '0, 4, -1, 16, $urandom);
        wait_quiet(1000);

        dv = $urandom;
        dv[7:0] = 8'hA5;
        run_phase(4'b0001, '0, 10, -1, 16, dv);
        wait_quiet(1000);

        run_phase(4'b0101, 4'b0101, 3, -1, 6, $urandom);
        wait_quiet(1000);

        run_phase(4'b0110, '0, 5, 1, 16, $urandom);
        wait_quiet(1000);

        run_phase(4'b0001, '0, TMO - 1, -1, 16, $urandom);
        wait_quiet(1000);

        run_phase(4'b1111, '0, 2, -1, 16, $urandom);
        wait_quiet(1000);

        run_phase(4'b1111, '0, 40, -1, 16, $urandom);
        repeat (10) tick();
        reset = 1'b0;
        #1;
        chk("midreset_ack", int'(ack), 0);
        chk("midreset_grant", int'(grant), 0);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_tx_start", int'(tx_start), 0);
        chk("midreset_tx_din", int'(tx_din), 0);
        chk("midreset_timeout_err", int'(timeout_err), 0);
        exp_q.delete();
        req  = '0;
        hold = '0;
        mptr = 0;
        tick();
        tick();
        reset = 1'b1;
        repeat (40) tick();
        stale = 1'b1;
        repeat (3) tick();
        chk("idle_after_stale_done", int'(busy), 0);
        run_phase(4'b1111, '0, 3, -1, 16, $urandom);
        wait_quiet(1000);

        for (int r = 0; r < 24; r++) begin
            pend = 4'($urandom_range(1, 15));
            n    = $urandom_range(1, 12);
            d    = -1;
            if ($urandom_range(0, 3) == 0) begin
                d = $urandom_range(0, 3);
                if (bitof(pend, d) == 0) d = -1;
            end
            run_phase(pend, '0, n, d, 16, $urandom);
            wait_quiet(2000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
